// File: rtl/fpro_bus_pkg.sv
// Shared constants and FSM state encoding for the FPro MMIO bus master.
package fpro_bus_pkg;
    localparam int ADDR_W   = 21;
    localparam int DATA_W   = 32;
    localparam int SLOT_LSB = 5;
    localparam int SLOT_W   = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WR,
        ST_RD_STB,
        ST_RD_RSP
    } state_t;
endpackage

// File: rtl/fpro_bus_master.sv
// FPro MMIO bus initiator: turns single/burst read-write commands from a
// streaming client into registered single-cycle bus strobes.
module fpro_bus_master #(
    parameter int ADDR_W = fpro_bus_pkg::ADDR_W,
    parameter int DATA_W = fpro_bus_pkg::DATA_W,
    parameter int LEN_W  = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              cmd_incr,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [DATA_W-1:0] wdata,
    output logic              rdata_valid,
    input  logic              rdata_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_last,
    output logic              busy,
    output logic              mmio_cs,
    output logic              mmio_wr,
    output logic              mmio_rd,
    output logic [ADDR_W-1:0] mmio_addr,
    output logic [DATA_W-1:0] mmio_wr_data,
    input  logic [DATA_W-1:0] mmio_rd_data
);
    import fpro_bus_pkg::*;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic                incr_q, incr_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                cs_d, wr_d, rd_d;
    logic [ADDR_W-1:0]   maddr_d;
    logic [DATA_W-1:0]   mdata_d;
    logic [ADDR_W-1:0]   addr_next;

    // Wraps modulo 2^ADDR_W; a fixed-address burst keeps hitting one FIFO register.
    function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] a,
                                                    input logic             inc);
        return a + {{(ADDR_W-1){1'b0}}, inc};
    endfunction

    assign addr_next   = step_addr(addr_q, incr_q);
    assign cmd_ready   = (state_q == ST_IDLE);
    assign wdata_ready = (state_q == ST_WR);
    assign rdata_valid = (state_q == ST_RD_RSP);
    assign rdata_last  = rdata_valid && (cnt_q == '0);
    assign rdata       = rdata_q;
    assign busy        = (state_q != ST_IDLE) || mmio_cs;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        incr_d  = incr_q;
        rdata_d = rdata_q;
        cs_d    = 1'b0;
        wr_d    = 1'b0;
        rd_d    = 1'b0;
        maddr_d = '0;
        mdata_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_d = cmd_addr;
                    cnt_d  = cmd_len;
                    incr_d = cmd_incr;
                    if (cmd_wr) begin
                        state_d = ST_WR;
                    end else begin
                        cs_d    = 1'b1;
                        rd_d    = 1'b1;
                        maddr_d = cmd_addr;
                        state_d = ST_RD_STB;
                    end
                end
            end
            ST_WR: begin
                if (wdata_valid) begin
                    cs_d    = 1'b1;
                    wr_d    = 1'b1;
                    maddr_d = addr_q;
                    mdata_d = wdata;
                    addr_d  = addr_next;
                    cnt_d   = cnt_q - LEN_W'(1);
                    if (cnt_q == '0)
                        state_d = ST_IDLE;
                end
            end
            ST_RD_STB: begin
                // The slave answers combinationally during the strobe cycle.
                rdata_d = mmio_rd_data;
                state_d = ST_RD_RSP;
            end
            ST_RD_RSP: begin
                if (rdata_ready) begin
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        addr_d  = addr_next;
                        cnt_d   = cnt_q - LEN_W'(1);
                        cs_d    = 1'b1;
                        rd_d    = 1'b1;
                        maddr_d = addr_next;
                        state_d = ST_RD_STB;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control, strobes and visible outputs reset; burst bookkeeping does not need to.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            rdata_q      <= '0;
            mmio_cs      <= 1'b0;
            mmio_wr      <= 1'b0;
            mmio_rd      <= 1'b0;
            mmio_addr    <= '0;
            mmio_wr_data <= '0;
        end else begin
            state_q      <= state_d;
            rdata_q      <= rdata_d;
            mmio_cs      <= cs_d;
            mmio_wr      <= wr_d;
            mmio_rd      <= rd_d;
            mmio_addr    <= maddr_d;
            mmio_wr_data <= mdata_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        cnt_q  <= cnt_d;
        incr_q <= incr_d;
    end

endmodule

// File: tb/tb_fpro_bus_master.sv
// Directed, table-driven bench for fpro_bus_master with a simple MMIO slave model.
module tb_fpro_bus_master;
    localparam int AW = 21;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cmd_valid, cmd_ready, cmd_wr, cmd_incr;
    logic [AW-1:0] cmd_addr;
    logic [4:0]    cmd_len;
    logic          wdata_valid, wdata_ready;
    logic [DW-1:0] wdata;
    logic          rdata_valid, rdata_ready, rdata_last;
    logic [DW-1:0] rdata;
    logic          busy, mmio_cs, mmio_wr, mmio_rd;
    logic [AW-1:0] mmio_addr;
    logic [DW-1:0] mmio_wr_data, mmio_rd_data;

    fpro_bus_master dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_incr(cmd_incr),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
        .rdata_last(rdata_last), .busy(busy),
        .mmio_cs(mmio_cs), .mmio_wr(mmio_wr), .mmio_rd(mmio_rd),
        .mmio_addr(mmio_addr), .mmio_wr_data(mmio_wr_data), .mmio_rd_data(mmio_rd_data)
    );

    always #5 clk = ~clk;

    // Slave model: read data = address ^ 0xDEAD0000 during the read strobe.
    assign mmio_rd_data = (mmio_cs && mmio_rd) ? ({11'd0, mmio_addr} ^ 32'hDEAD0000) : 32'd0;

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        int            len;
        bit            incr;
        int            nbeats;
        logic [AW-1:0] a_last;
    } vec_t;

    vec_t          vecs[6];
    int            total = 0;
    int            bad   = 0;
    int            cyc   = 0;
    logic [AW-1:0] q_addr[$];
    logic [DW-1:0] q_data[$];
    bit            q_wr[$];
    int            q_cyc[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every cycle advance goes through here: bus invariants and strobe logging.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        chk("no_wr_rd_overlap", 64'(mmio_wr & mmio_rd), 64'd0);
        if (!mmio_cs)
            chk("idle_bus_zero", 64'({mmio_wr, mmio_rd, mmio_addr, mmio_wr_data}), 64'd0);
        if (mmio_cs) begin
            q_addr.push_back(mmio_addr);
            q_data.push_back(mmio_wr_data);
            q_wr.push_back(mmio_wr);
            q_cyc.push_back(cyc);
        end
    endtask

    task automatic issue_cmd(input bit wr, input logic [AW-1:0] a, input int len, input bit inc);
        int n;
        n = 0;
        cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_len = 5'(len); cmd_incr = inc;
        while (!cmd_ready && n < 50) begin tick(); n++; end
        chk("cmd_ready_wait", 64'(cmd_ready), 64'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic do_write(input vec_t v, input logic [DW-1:0] d0);
        int            base, n;
        int            hs[32];
        logic [AW-1:0] ea;
        base = q_addr.size();
        issue_cmd(1'b1, v.addr, v.len, v.incr);
        for (int b = 0; b <= v.len; b++) begin
            wdata_valid = 1'b1;
            wdata = d0 + DW'(b) * 32'h101;
            n = 0;
            while (!wdata_ready && n < 20) begin tick(); n++; end
            chk("wdata_ready_wait", 64'(wdata_ready), 64'd1);
            tick();
            hs[b] = cyc;
        end
        wdata_valid = 1'b0;
        repeat (3) tick();
        chk("wr_count", 64'(q_addr.size() - base), 64'(v.nbeats));
        for (int b = 0; b < v.nbeats && base + b < q_addr.size(); b++) begin
            ea = v.addr + (v.incr ? AW'(b) : AW'(0));
            chk("wr_kind", 64'(q_wr[base+b]), 64'd1);
            chk("wr_addr", 64'(q_addr[base+b]), 64'(ea));
            chk("wr_data", 64'(q_data[base+b]), 64'(d0 + DW'(b) * 32'h101));
            chk("wr_cycle", 64'(q_cyc[base+b]), 64'(hs[b]));
        end
        if (q_addr.size() == base + v.nbeats)
            chk("wr_last_addr", 64'(q_addr[base+v.nbeats-1]), 64'(v.a_last));
    endtask

    task automatic do_read(input vec_t v, input int stall_beat, input int stall_n);
        int            base, n, gap;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        base = q_addr.size();
        rdata_ready = 1'b0;
        issue_cmd(1'b0, v.addr, v.len, v.incr);
        chk("rd_first_strobe", 64'({mmio_cs, mmio_rd, rdata_valid}), 64'b110);
        for (int b = 0; b <= v.len; b++) begin
            ea = v.addr + (v.incr ? AW'(b) : AW'(0));
            ed = {11'd0, ea} ^ 32'hDEAD0000;
            n = 0;
            while (!rdata_valid && n < 20) begin tick(); n++; end
            chk("rd_valid_wait", 64'(rdata_valid), 64'd1);
            chk("rd_data", 64'(rdata), 64'(ed));
            chk("rd_last", 64'(rdata_last), 64'(b == v.len));
            if (b == stall_beat) begin
                for (int s = 0; s < stall_n; s++) begin
                    tick();
                    chk("stall_data", 64'(rdata), 64'(ed));
                    chk("stall_valid", 64'(rdata_valid), 64'd1);
                    chk("stall_no_strobe", 64'(mmio_cs), 64'd0);
                end
            end
            rdata_ready = 1'b1;
            tick();
            rdata_ready = 1'b0;
        end
        repeat (3) tick();
        chk("rd_count", 64'(q_addr.size() - base), 64'(v.nbeats));
        for (int b = 0; b < v.nbeats && base + b < q_addr.size(); b++) begin
            ea = v.addr + (v.incr ? AW'(b) : AW'(0));
            chk("rd_kind", 64'(q_wr[base+b]), 64'd0);
            chk("rd_addr", 64'(q_addr[base+b]), 64'(ea));
            if (b > 0) begin
                gap = 2 + ((b - 1 == stall_beat) ? stall_n : 0);
                chk("rd_spacing", 64'(q_cyc[base+b] - q_cyc[base+b-1]), 64'(gap));
            end
        end
        if (q_addr.size() == base + v.nbeats)
            chk("rd_last_addr", 64'(q_addr[base+v.nbeats-1]), 64'(v.a_last));
    endtask

    initial begin
        int base, idx;
        int hs[4];
        int pat[7];
        bit rdy;

        vecs[0] = '{1'b1, 21'h000040, 0, 1'b1, 1, 21'h000040};
        vecs[1] = '{1'b1, 21'h1FFFFF, 1, 1'b1, 2, 21'h000000};
        vecs[2] = '{1'b1, 21'h1FFFFF, 1, 1'b0, 2, 21'h1FFFFF};
        vecs[3] = '{1'b0, 21'h000060, 3, 1'b1, 4, 21'h000063};
        vecs[4] = '{1'b0, 21'h1FFFFF, 2, 1'b1, 3, 21'h000001};
        vecs[5] = '{1'b1, 21'h000123, 4, 1'b0, 5, 21'h000123};
        pat = '{1, 0, 0, 1, 1, 0, 1};

        reset_n = 1'b0;
        cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_incr = 1'b0;
        wdata_valid = 1'b0; wdata = '0; rdata_ready = 1'b0;
        repeat (3) tick();
        chk("reset_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("reset_outputs", 64'({wdata_ready, rdata_valid, rdata_last, busy, mmio_cs,
                                  mmio_wr, mmio_rd}), 64'd0);
        chk("reset_rdata", 64'(rdata), 64'd0);
        reset_n = 1'b1;
        tick();

        // Single write: one strobe cycle, busy still high in it, low right after.
        issue_cmd(1'b1, 21'h040, 0, 1'b1);
        wdata_valid = 1'b1; wdata = 32'h000000A5;
        chk("single_wdata_ready", 64'(wdata_ready), 64'd1);
        tick();
        wdata_valid = 1'b0;
        chk("single_strobe", 64'({mmio_cs, mmio_wr, mmio_rd, busy, cmd_ready}), 64'b11011);
        chk("single_addr", 64'(mmio_addr), 64'h040);
        chk("single_data", 64'(mmio_wr_data), 64'hA5);
        tick();
        chk("single_after", 64'({mmio_cs, busy}), 64'd0);

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].wr)
                do_write(vecs[i], 32'h000000A5 + DW'(i) * 32'h01000000);
            else
                do_read(vecs[i], -1, 0);
        end

        // Read backpressure: 5-cycle stall on beat 2 of a 3-beat burst.
        do_read('{1'b0, 21'h000100, 2, 1'b1, 3, 21'h000102}, 1, 5);

        // Write with gaps in wdata_valid.
        base = q_addr.size();
        idx = 0;
        issue_cmd(1'b1, 21'h000300, 3, 1'b1);
        for (int i = 0; i < 7; i++) begin
            wdata_valid = pat[i][0];
            wdata = 32'hC0DE0000 + DW'(idx);
            rdy = wdata_ready;
            tick();
            if (pat[i] == 1 && rdy) begin
                if (idx < 4) hs[idx] = cyc;
                idx++;
            end
        end
        wdata_valid = 1'b0;
        repeat (2) tick();
        chk("gap_handshakes", 64'(idx), 64'd4);
        chk("gap_count", 64'(q_addr.size() - base), 64'd4);
        for (int b = 0; b < 4 && base + b < q_addr.size(); b++) begin
            chk("gap_data", 64'(q_data[base+b]), 64'(32'hC0DE0000 + DW'(b)));
            chk("gap_addr", 64'(q_addr[base+b]), 64'(21'h300 + AW'(b)));
            chk("gap_cycle", 64'(q_cyc[base+b]), 64'(hs[b]));
        end

        // Command accepted in the cycle carrying the final write strobe.
        issue_cmd(1'b1, 21'h000080, 0, 1'b1);
        wdata_valid = 1'b1; wdata = 32'h12345678;
        tick();
        wdata_valid = 1'b0;
        chk("b2b_wr_strobe", 64'({mmio_cs, mmio_wr, cmd_ready}), 64'b111);
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 21'h0A0; cmd_len = 5'd0; cmd_incr = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("b2b_rd_strobe", 64'({mmio_cs, mmio_rd, mmio_wr}), 64'b110);
        chk("b2b_rd_addr", 64'(mmio_addr), 64'h0A0);
        tick();
        chk("b2b_rdata", 64'({rdata_valid, rdata_last, rdata}), {30'd0, 2'b11, 32'hDEAD00A0});
        rdata_ready = 1'b1;
        tick();
        rdata_ready = 1'b0;
        chk("b2b_idle", 64'({busy, cmd_ready}), 64'b01);

        // Reset asserted during the strobe cycle drops the strobe at once.
        issue_cmd(1'b0, 21'h000400, 7, 1'b1);
        chk("rst_stb_pre", 64'(mmio_rd), 64'd1);
        #3 reset_n = 1'b0;
        #1 chk("rst_stb_drop", 64'({mmio_cs, mmio_rd, busy, cmd_ready}), 64'b0001);
        tick();
        reset_n = 1'b1;

        // Reset asserted while holding read data.
        issue_cmd(1'b0, 21'h000200, 7, 1'b1);
        tick();
        chk("rst_rsp_pre", 64'(rdata_valid), 64'd1);
        #3 reset_n = 1'b0;
        #1 chk("rst_rsp_drop", 64'({rdata_valid, rdata_last, mmio_cs, mmio_rd, busy, cmd_ready}),
               64'b000001);
        tick();
        reset_n = 1'b1;
        base = q_addr.size();
        rdata_ready = 1'b1;
        repeat (10) tick();
        rdata_ready = 1'b0;
        chk("rst_no_strobes", 64'(q_addr.size() - base), 64'd0);
        chk("rst_after", 64'({cmd_ready, rdata_valid, busy}), 64'b100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fpro_bus_master.md
# fpro_bus_master

Initiator side of the FPro MMIO bus: converts single or burst read/write commands from a streaming client (debug bridge, DMA sequencer) into FPro bus strobes toward the MMIO subsystem. It returns read data on a valid/ready stream. It sits between an on-chip client and the MMIO controller, and replaces the processor as bus owner.

## Interface
- ADDR_W, 21, FPro MMIO word address width; slot = addr[10:5], register = addr[4:0]
- DATA_W, 32, bus data width
- LEN_W, 5, burst length field width (beats = cmd_len+1, max 32)

Clocking and reset: one clock; reset is asynchronous and active-low.

- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when both high
- cmd_wr  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  ADDR_W  first beat address
- cmd_len  in  LEN_W  beats minus one
- cmd_incr  in  1  1 = address +1 per beat; 0 = fixed address (FIFO-style register)
- wdata_valid / wdata_ready  in / out  1  write-data handshake
- wdata  in  DATA_W  write beat
- rdata_valid / rdata_ready  out / in  1  read-response handshake
- rdata  out  DATA_W  read beat
- rdata_last  out  1  final beat of the read burst
- busy  out  1  state != IDLE or strobe in flight
- mmio_cs, mmio_wr, mmio_rd  out  1  bus strobes, registered, single-cycle per beat
- mmio_addr  out  ADDR_W  registered
- mmio_wr_data  out  DATA_W  registered
- mmio_rd_data  in  DATA_W  combinational response, valid during the mmio_rd cycle

## Operation
- States:
  - IDLE
  - WR (accepting write beats)
  - RD_STB (read strobe on bus)
  - RD_RSP (holding rdata)
- cmd_ready = (state == IDLE).
- On command accept, latch addr, the beat counter (cmd_len) and incr.
- WR:
  - wdata_ready = 1.
  - Each wdata handshake registers cs=wr=1, addr and data for exactly the next cycle.
  - Each handshake then advances addr and decrements the counter.
  - The last beat returns the FSM to IDLE.
  - The final strobe fires in the first IDLE cycle, and busy stays high during it.
- Read:
  - Command accept registers cs=rd=1 with addr, and the FSM goes to RD_STB.
  - At the end of RD_STB, capture mmio_rd_data into rdata and go to RD_RSP. rdata_valid = 1; rdata_last = (counter == 0).
  - On the rdata handshake in RD_RSP:
    - If the counter == 0, go to IDLE.
    - Otherwise, advance addr, decrement the counter, register the next strobe and go to RD_STB.
- Address arithmetic is modulo 2^ADDR_W: 0x1FFFFF + 1 = 0x000000. With cmd_incr = 0, the address is unchanged on every beat.
- When cs = 0: mmio_wr = mmio_rd = 0, and mmio_addr and mmio_wr_data drive 0.
- Never assert mmio_wr and mmio_rd together.
- wdata is ignored (wdata_ready = 0) outside WR. rdata_ready is ignored outside RD_RSP.
- rdata and rdata_last hold stable while rdata_valid is high and rdata_ready is low. No further strobe is issued during that wait.

## Timing
- Reset value of every output is 0, except cmd_ready = 1. State = IDLE.
- reset_n assertion mid-burst drops the burst immediately. Strobes deassert asynchronously, and no partial beat completes.
- Write throughput: 1 beat/cycle with wdata_valid held high. Strobe appears 1 cycle after its handshake.
- Read latency: command accept at edge N → strobe in cycle N+1 → rdata_valid in cycle N+2.
- Read throughput: 1 beat per 2 cycles with rdata_ready held high.
- A new command can be accepted in the IDLE cycle that carries the final write strobe. Its first strobe is ≥1 cycle later.

## Structure
- Package fpro_bus_pkg holds:
  - ADDR_W and DATA_W constants
  - SLOT_LSB = 5 and SLOT_W = 6
  - the state enum typedef
- Single module with no sub-module. Beat counter, address register and FSM are inline.

## Test plan
- Single write: cmd_wr = 1, addr 0x040 (slot 2, reg 0), len 0, wdata 0x000000A5 → exactly one cycle of cs=wr=1, addr 0x040, data 0xA5. rd stays 0, and busy falls 1 cycle later.
- Read burst: addr 0x060, len 3, incr 1; bus model returns data = addr ^ 0xDEAD0000 → 4 rdata beats 0xDEAD0060..0xDEAD0063. rdata_last only on the 4th beat, and strobes spaced 2 cycles apart.
- Read backpressure: rdata_ready low for 5 cycles on beat 2 of len 2 → rdata stable and no strobe during the stall. Exactly 3 rd strobes total.
- Wrap and fixed addressing:
  - Write at 0x1FFFFF, len 1, incr 1 → strobe addresses 0x1FFFFF then 0x000000.
  - Same with incr 0 → 0x1FFFFF twice.
- Write gaps: len 3, with wdata_valid toggling 1,0,0,1,1,0,1 → exactly 4 write strobes, each 1 cycle after a handshake, with data in order.
- Reset mid-read: reset_n low during RD_RSP of a len 7 burst → all strobes and rdata_valid go 0 immediately. cmd_ready = 1 after release, and no further strobes occur.
